// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 32-bit to 2x16-bit SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } sram_state_e;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 3;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0000_0400;
  localparam int unsigned DEFAULT_SRAM_AW     = 18;

  // Width of a counter that must hold 0..wait_cycles-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles > 1) ? int'($clog2(wait_cycles)) : 1;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Phase counter: counts 0..WAIT_CYCLES-1, flags the last cycle of a phase.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   CW   = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tc_q;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register; terminal flag is registered from the next count so it is glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= (LAST == '0);
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == LAST);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/sram_ctrl.sv
// Splits one 32-bit load/store into two 16-bit SRAM accesses with wait states.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  localparam int unsigned WORD_W = SRAM_AW - 1;

  sram_state_e        state_q;
  logic               is_wr_q;
  logic [WORD_W-1:0]  word_q;
  logic [15:0]        wdata_hi_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic               sram_we_n_q;
  logic [15:0]        sram_dq_out_q;
  logic               sram_dq_oe_q;

  logic              req_c;
  logic              busy_c;
  logic              tc;
  logic [WORD_W-1:0] req_word_c;

  assign req_c      = wr_en | rd_en;
  assign busy_c     = (state_q == S_LO) || (state_q == S_HI);
  // Word index relative to the SRAM window; out-of-range addresses wrap silently.
  assign req_word_c = WORD_W'((address - BASE_ADDR) >> 2);

  // Per-phase wait counter, held clear outside LO/HI and cleared on each phase change.
  sram_wait_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~busy_c | tc),
    .en_i  (busy_c),
    .tc_o  (tc)
  );

  // Access FSM; SRAM pins are loaded on the edge that enters each phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      is_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_hi_q    <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_we_n_q   <= 1'b1;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_c) begin
            state_q       <= S_LO;
            is_wr_q       <= wr_en;
            word_q        <= req_word_c;
            wdata_hi_q    <= write_data[31:16];
            sram_addr_q   <= {req_word_c, 1'b0};
            sram_we_n_q   <= ~wr_en;
            sram_dq_oe_q  <= wr_en;
            sram_dq_out_q <= wr_en ? write_data[15:0] : 16'h0000;
          end
        end
        S_LO: begin
          if (tc) begin
            state_q     <= S_HI;
            sram_addr_q <= {word_q, 1'b1};
            if (is_wr_q) begin
              sram_dq_out_q <= wdata_hi_q;
            end else begin
              read_data_q[15:0] <= sram_dq_in;
            end
          end
        end
        S_HI: begin
          if (tc) begin
            state_q      <= S_DONE;
            sram_we_n_q  <= 1'b1;
            sram_dq_oe_q <= 1'b0;
            if (!is_wr_q) begin
              read_data_q[31:16] <= sram_dq_in;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is the only combinational output: it must drop in the cycle a request appears.
  assign ready = (state_q == S_IDLE) ? ~req_c : (state_q == S_DONE);

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: transaction-level model with per-cycle compare, plus a WAIT_CYCLES=1 instance.
module tb_sram_ctrl;

  localparam int unsigned W     = 3;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int unsigned AW    = 18;
  localparam int unsigned HWS   = 1 << AW;
  localparam int unsigned WORDS = 1 << (AW - 1);

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // ---------------- W=3 instance ----------------
  logic          wr_en, rd_en;
  logic [31:0]   address, write_data, read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n, sram_dq_oe;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic [15:0]   sram0 [0:HWS-1];

  sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  // ---------------- W=1 instance ----------------
  logic          wr1, rd1;
  logic [31:0]   addr1, wdata1, rdata1;
  logic          ready1;
  logic [AW-1:0] sram_addr1;
  logic          we_n1, oe1;
  logic [15:0]   dq_out1, dq_in1;
  logic [15:0]   sram1 [0:HWS-1];

  sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
    .write_data(wdata1), .read_data(rdata1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_we_n(we_n1), .sram_dq_out(dq_out1),
    .sram_dq_oe(oe1), .sram_dq_in(dq_in1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16-bit SRAMs: write on clock while we_n low and bus driven.
  assign sram_dq_in = sram_dq_oe ? sram_dq_out : sram0[sram_addr];
  assign dq_in1     = oe1 ? dq_out1 : sram1[sram_addr1];

  initial begin
    for (int i = 0; i < HWS; i++) sram0[i] = 16'h0000;
    forever begin
      @(posedge clk);
      if (!sram_we_n && sram_dq_oe) sram0[sram_addr] <= sram_dq_out;
    end
  end

  initial begin
    for (int i = 0; i < HWS; i++) sram1[i] = 16'h0000;
    forever begin
      @(posedge clk);
      if (!we_n1 && oe1) sram1[sram_addr1] <= dq_out1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-2:0] word_of(input logic [31:0] a);
    return (AW-1)'((a - BASE) >> 2);
  endfunction

  // ---------------- reference model + per-cycle compare (W=3 instance) ----------------
  logic [31:0]   ref_mem [0:WORDS-1];
  logic          m_active, m_wr;
  int            m_k;
  logic [AW-2:0] m_word;
  logic [31:0]   m_data, m_rdata;

  initial begin
    logic hi;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
    m_active = 1'b0; m_rdata = 32'h0; m_k = 0; m_wr = 1'b0; m_word = '0; m_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_active = 1'b0;
        m_rdata  = 32'h0;
        chk("rst_addr",  32'(sram_addr), 32'h0);
        chk("rst_we_n",  32'(sram_we_n), 32'h1);
        chk("rst_oe",    32'(sram_dq_oe), 32'h0);
        chk("rst_dqout", 32'(sram_dq_out), 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_ready", 32'(ready), 32'(!(wr_en || rd_en)));
      end else if (!m_active) begin
        chk("idle_ready", 32'(ready), 32'(!(wr_en || rd_en)));
        chk("idle_we_n",  32'(sram_we_n), 32'h1);
        chk("idle_oe",    32'(sram_dq_oe), 32'h0);
        chk("idle_rdata", read_data, m_rdata);
        if (wr_en || rd_en) begin
          m_active = 1'b1;
          m_k      = 0;
          m_wr     = wr_en;
          m_word   = word_of(address);
          m_data   = write_data;
        end
      end else begin
        m_k++;
        if (m_k <= 2 * W) begin
          hi = (m_k > W);
          chk("busy_ready", 32'(ready), 32'h0);
          chk("busy_addr",  32'(sram_addr), 32'({m_word, hi}));
          chk("busy_we_n",  32'(sram_we_n), 32'(!m_wr));
          chk("busy_oe",    32'(sram_dq_oe), 32'(m_wr));
          if (m_wr) chk("busy_dq", 32'(sram_dq_out), hi ? 32'(m_data[31:16]) : 32'(m_data[15:0]));
        end else begin
          if (m_wr) ref_mem[m_word] = m_data;
          else      m_rdata = ref_mem[m_word];
          chk("done_ready", 32'(ready), 32'h1);
          chk("done_we_n",  32'(sram_we_n), 32'h1);
          chk("done_oe",    32'(sram_dq_oe), 32'h0);
          chk("done_rdata", read_data, m_rdata);
          m_active = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Drive a request and wait for ready; returns the cycle index (request cycle = 0) of ready.
  task automatic run(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     output int lat);
    int n;
    wr_en = w; rd_en = r; address = a; write_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (ready || n >= 40) break;
    end
    chk("ready_timeout", 32'(ready), 32'h1);
    lat = n - 1;
  endtask

  task automatic run1(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      output int lat);
    int n;
    wr1 = w; rd1 = r; addr1 = a; wdata1 = d;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (ready1 || n >= 40) break;
    end
    chk("ready1_timeout", 32'(ready1), 32'h1);
    lat = n - 1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, lat2;
    logic w, r;
    logic [31:0] a, d;
    checks = 0; errors = 0;
    rst = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; write_data = 32'h0;
    wr1 = 1'b0; rd1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Basic write and read-back.
    run(1'b1, 1'b0, 32'h400, 32'hDEADBEEF, lat);
    chk("wr_latency", 32'(lat), 32'd7);
    chk("sram_0", 32'(sram0[0]), 32'h0000BEEF);
    chk("sram_1", 32'(sram0[1]), 32'h0000DEAD);
    step(); idle();
    step();
    run(1'b0, 1'b1, 32'h400, 32'h0, lat);
    chk("rd_latency", 32'(lat), 32'd7);
    chk("rd_data", read_data, 32'hDEADBEEF);
    step(); idle();
    repeat (3) step();
    chk("rd_hold", read_data, 32'hDEADBEEF);

    // Address mapping, including ignored low bits.
    run(1'b1, 1'b0, 32'h40C, 32'h12345678, lat);
    chk("map_lo", 32'(sram0[6]), 32'h00005678);
    chk("map_hi", 32'(sram0[7]), 32'h00001234);
    step(); idle(); step();
    run(1'b1, 1'b0, 32'h40F, 32'hA5A55A5A, lat);
    chk("map11_lo", 32'(sram0[6]), 32'h00005A5A);
    chk("map11_hi", 32'(sram0[7]), 32'h0000A5A5);
    step(); idle(); step();
    run(1'b0, 1'b1, 32'h40D, 32'h0, lat);
    chk("map_rd", read_data, 32'hA5A55A5A);
    step(); idle(); step();

    // Write wins when both requests are present.
    run(1'b1, 1'b1, 32'h410, 32'h0BADF00D, lat);
    chk("prio_lo", 32'(sram0[8]), 32'h0000F00D);
    chk("prio_hi", 32'(sram0[9]), 32'h00000BAD);
    chk("prio_rdata", read_data, 32'hA5A55A5A);
    step(); idle(); step();

    // Back-to-back write then read with requests held continuously.
    run(1'b1, 1'b0, 32'h414, 32'h11223344, lat);
    step();
    run(1'b0, 1'b1, 32'h414, 32'h0, lat2);
    chk("b2b_cycles", 32'(lat + 1 + lat2 + 1), 32'd16);
    chk("b2b_rdata", read_data, 32'h11223344);
    step(); idle(); step();

    // Randomized traffic: words 8..39 plus wrapped addresses below BASE.
    for (int t = 0; t < 150; t++) begin
      w = 1'($urandom_range(0, 1));
      r = !w || ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) a = BASE - 32'(4 * $urandom_range(1, 2));
      else a = BASE + 32'(4 * $urandom_range(8, 39)) + 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        wr_en = w; rd_en = r; address = a; write_data = d;
        step(); idle();
        repeat (2 * W + 1) step();
      end else begin
        run(w, r, a, d, lat);
        step();
        if ($urandom_range(0, 1) == 0) begin
          idle();
          repeat ($urandom_range(0, 3)) step();
        end
      end
    end
    idle();
    repeat (2 * W + 2) step();

    // Reset in the middle of a write's LO phase.
    wr_en = 1'b1; rd_en = 1'b0; address = BASE + 32'd400; write_data = 32'hFEEDFACE;
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("arst_we_n", 32'(sram_we_n), 32'h1);
    chk("arst_oe",   32'(sram_dq_oe), 32'h0);
    chk("arst_busy_ready", 32'(ready), 32'h0);
    idle();
    #1;
    chk("arst_ready", 32'(ready), 32'h1);
    step();
    rst = 1'b1;
    step();
    run(1'b0, 1'b1, 32'h414, 32'h0, lat);
    chk("post_rst_lat", 32'(lat), 32'd7);
    chk("post_rst_rd", read_data, 32'h11223344);
    step(); idle(); step();

    // WAIT_CYCLES=1 instance.
    run1(1'b1, 1'b0, 32'h404, 32'hCAFEF00D, lat);
    chk("w1_wr_lat", 32'(lat), 32'd3);
    chk("w1_sram_lo", 32'(sram1[2]), 32'h0000F00D);
    chk("w1_sram_hi", 32'(sram1[3]), 32'h0000CAFE);
    step(); wr1 = 1'b0; rd1 = 1'b0; step();
    run1(1'b0, 1'b1, 32'h404, 32'h0, lat);
    chk("w1_rd_lat", 32'(lat), 32'd3);
    chk("w1_rd_data", rdata1, 32'hCAFEF00D);
    step(); wr1 = 1'b0; rd1 = 1'b0;

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
